// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32 control FSM: opcodes, state codes, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multi_cycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic PC_SRC_PC4    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  // Full datapath control word; all-zero is the idle/safe value.
  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
  } ctrl_t;

  // Opcodes that take the normal ID -> EX path.
  function automatic logic is_exec_op(input logic [6:0] op);
    return (op == OP_RTYPE)  || (op == OP_IARITH) || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JAL)  ||
           (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath/memory signal bundle.
// Latency: n/a (wires only).
// Backpressure: memory stalls via mem_ready; no other flow control.
interface multi_cycle_controller_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       mem_ready;
  logic       halt_req;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic       alu_src_b;
  logic [1:0] alu_op;
  logic       pc_source;
  logic       is_halted;
  logic       mem_error;
  logic [2:0] state;

  modport master (
    input  opcode, bcond, mem_ready, halt_req,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           is_halted, mem_error, state
  );

  modport slave (
    output opcode, bcond, mem_ready, halt_req,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           is_halted, mem_error, state
  );
endinterface

// File: rtl/multi_cycle_controller_mem_wait_timer.sv
// Counts stalled memory-wait cycles and flags a timeout at MEM_TIMEOUT.
// Latency: timeout is combinational from the registered count.
// Backpressure: none; mem_ready in the timeout cycle suppresses the flag.
module mem_wait_timer
  import multi_cycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout = wait_active && !mem_ready && (cnt_q == CW'(MEM_TIMEOUT));

  // Count while stalled; any other cycle leaves zero behind so the next wait starts fresh.
  always_comb begin
    cnt_d = '0;
    if (wait_active && !mem_ready && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32 control FSM (IF/ID/EX/MEM/WB/HALT); ECALL_HALT_EN lets ECALL+halt_req stop the core.
// Latency: controls are combinational from the current state; one state transition per clock.
// Backpressure: IF and MEM stall on mem_ready; MEM_TIMEOUT stalled cycles force HALT with mem_error.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  multi_cycle_controller_if.master      bus
);

  state_e state_q, state_d;
  logic   mem_error_q, mem_error_d;
  ctrl_t  ctrl;
  logic   wait_active;
  logic   timeout;

`ifndef ECALL_HALT_EN
  logic halt_req_unused;
  assign halt_req_unused = bus.halt_req;
`endif

  assign wait_active = (state_q == ST_IF) ||
                       ((state_q == ST_MEM) &&
                        ((bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE)));

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .wait_active (wait_active),
    .mem_ready   (bus.mem_ready),
    .timeout     (timeout)
  );

  // Next state, sticky error and per-state control word; reset masks every enable.
  always_comb begin
    state_d     = state_q;
    mem_error_d = mem_error_q;
    ctrl        = '0;
    case (state_q)
      ST_IF: begin
        ctrl.mem_read = 1'b1;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          state_d       = ST_ID;
        end else if (timeout) begin
          state_d     = ST_HALT;
          mem_error_d = 1'b1;
        end
      end
      ST_ID: begin
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        if (bus.opcode == OP_SYSTEM) begin
`ifdef ECALL_HALT_EN
          if (bus.halt_req) begin
            state_d = ST_HALT;
          end else begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_PC4;
            state_d        = ST_IF;
          end
`else
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_PC4;
          state_d        = ST_IF;
`endif
        end else if (is_exec_op(bus.opcode)) begin
          state_d = ST_EX;
        end else begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_PC4;
          state_d        = ST_IF;
        end
      end
      ST_EX: begin
        state_d = ST_WB;
        case (bus.opcode)
          OP_RTYPE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OP_IARITH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 1'b1;
            state_d        = ST_MEM;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_BRANCH;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = bus.bcond;
            state_d        = ST_IF;
          end
          OP_JALR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 1'b1;
          end
          OP_JAL: begin
          end
          default: state_d = ST_IF;
        endcase
      end
      ST_MEM: begin
        ctrl.i_or_d = 1'b1;
        if (bus.opcode == OP_LOAD) begin
          ctrl.mem_read = 1'b1;
        end else if (bus.opcode == OP_STORE) begin
          ctrl.mem_write = 1'b1;
        end
        if (!wait_active) begin
          ctrl    = '0;
          state_d = ST_IF;
        end else if (bus.mem_ready) begin
          if (bus.opcode == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_PC4;
            state_d        = ST_IF;
          end
        end else if (timeout) begin
          state_d     = ST_HALT;
          mem_error_d = 1'b1;
        end
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        if (bus.opcode == OP_LOAD) begin
          ctrl.mem_to_reg = WB_MDR;
        end else if ((bus.opcode == OP_JAL) || (bus.opcode == OP_JALR)) begin
          ctrl.mem_to_reg = WB_PC4;
          ctrl.pc_source  = PC_SRC_ALUOUT;
        end
        state_d = ST_IF;
      end
      ST_HALT: begin
      end
      default: state_d = ST_IF;
    endcase
    if (reset) begin
      ctrl = '0;
    end
  end

  // State and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IF;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign bus.pc_write   = ctrl.pc_write;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_source  = ctrl.pc_source;
  assign bus.state      = state_q;
  assign bus.is_halted  = (state_q == ST_HALT);
  assign bus.mem_error  = mem_error_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized instruction stream against a per-instruction cycle model with a scoreboard monitor.
// Latency: one expected record per clock, compared at the falling edge.
// Backpressure: memory waits and timeouts are driven through mem_ready.
module tb_multi_cycle_controller;
  import multi_cycle_controller_pkg::*;

  localparam int TO = 4;
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_HALT = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, iod, mrd, mwr, irw, rgw;
    logic [1:0] m2r;
    logic       sa, sb;
    logic [1:0] aop;
    logic       pcs;
    logic       hlt, merr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  multi_cycle_controller_if bus();

  multi_cycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   m_merr = 1'b0;
  bit   m_halt = 1'b0;

  // Monitor: every cycle with a pending expectation is compared in full.
  always @(negedge clk) begin
    exp_t x, act;
    if (exp_q.size() > 0) begin
      x   = exp_q.pop_front();
      act = {bus.state, bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write,
             bus.ir_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
             bus.alu_src_b, bus.alu_op, bus.pc_source, bus.is_halted, bus.mem_error};
      tests++;
      if (act !== x) begin
        fails++;
        $display("FAIL cycle_check t=%0t opcode=%b actual=%b required=%b (st|pcw iod mrd mwr irw rgw|m2r|sa sb|aop|pcs|hlt merr)",
                 $time, bus.opcode, act, x);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    return logic'($urandom % 2);
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t x;
    x      = '0;
    x.st   = st;
    x.hlt  = (st == S_HALT);
    x.merr = m_merr;
    return x;
  endfunction

  task automatic step(input logic [6:0] opc, input logic rdy, input logic bc,
                      input logic hr, input logic rst, input exp_t x);
    bus.opcode    = opc;
    bus.mem_ready = rdy;
    bus.bcond     = bc;
    bus.halt_req  = hr;
    reset         = rst;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // n stalled cycles then one ready cycle; stall number TO+1 ends in HALT.
  task automatic do_wait(input logic [6:0] opc, input exp_t busy, input exp_t done,
                         input int n, output bit to);
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(opc, 1'b0, rb(), rb(), 1'b0, busy);
      if (i == TO) begin
        to     = 1'b1;
        m_merr = 1'b1;
        m_halt = 1'b1;
        return;
      end
    end
    step(opc, 1'b1, rb(), rb(), 1'b0, done);
  endtask

  task automatic run_instr(input logic [6:0] opc, input int if_n, input int mem_n,
                           input logic bc, input logic hr);
    exp_t x, y;
    bit   to;
    bit   is_ls, is_j;
    is_ls = (opc == OP_LOAD) || (opc == OP_STORE);
    is_j  = (opc == OP_JAL) || (opc == OP_JALR);
    x = blank(S_IF); x.mrd = 1'b1;
    y = x;           y.irw = 1'b1;
    do_wait(opc, x, y, if_n, to);
    if (to) return;
    x = blank(S_ID); x.sb = 1'b1;
    if (opc == OP_SYSTEM) begin
`ifdef ECALL_HALT_EN
      if (hr) begin
        step(opc, rb(), rb(), 1'b1, 1'b0, x);
        m_halt = 1'b1;
        return;
      end
`endif
      x.pcw = 1'b1;
      step(opc, rb(), rb(), hr, 1'b0, x);
      return;
    end
    if (!(opc inside {OP_RTYPE, OP_IARITH, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR})) begin
      x.pcw = 1'b1;
      step(opc, rb(), rb(), rb(), 1'b0, x);
      return;
    end
    step(opc, rb(), rb(), rb(), 1'b0, x);
    x = blank(S_EX);
    if (opc == OP_RTYPE)  begin x.sa = 1'b1; x.aop = 2'd2; end
    if (opc == OP_IARITH) begin x.sa = 1'b1; x.sb = 1'b1; x.aop = 2'd2; end
    if (is_ls || opc == OP_JALR) begin x.sa = 1'b1; x.sb = 1'b1; end
    if (opc == OP_BRANCH) begin x.sa = 1'b1; x.aop = 2'd1; x.pcw = 1'b1; x.pcs = bc; end
    step(opc, rb(), bc, rb(), 1'b0, x);
    if (opc == OP_BRANCH) return;
    if (is_ls) begin
      x = blank(S_MEM); x.iod = 1'b1;
      if (opc == OP_LOAD) x.mrd = 1'b1; else x.mwr = 1'b1;
      y = x;
      if (opc == OP_STORE) y.pcw = 1'b1;
      do_wait(opc, x, y, mem_n, to);
      if (to || opc == OP_STORE) return;
    end
    x = blank(S_WB); x.rgw = 1'b1; x.pcw = 1'b1;
    x.m2r = (opc == OP_LOAD) ? 2'd1 : (is_j ? 2'd2 : 2'd0);
    x.pcs = is_j;
    step(opc, rb(), rb(), rb(), 1'b0, x);
  endtask

  // HALT must ignore all inputs; only reset leaves it.
  task automatic recover();
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      step(7'($urandom), rb(), rb(), rb(), 1'b0, blank(S_HALT));
    end
    x = blank(S_HALT);
    step(7'($urandom), 1'b1, rb(), rb(), 1'b1, x);
    m_merr = 1'b0;
    m_halt = 1'b0;
  endtask

  // Reset lands on a load's MEM cycle together with mem_ready: nothing may be written.
  task automatic reset_in_mem();
    exp_t x;
    x = blank(S_IF);  x.mrd = 1'b1; x.irw = 1'b1;
    step(OP_LOAD, 1'b1, rb(), rb(), 1'b0, x);
    x = blank(S_ID);  x.sb = 1'b1;
    step(OP_LOAD, 1'b0, rb(), rb(), 1'b0, x);
    x = blank(S_EX);  x.sa = 1'b1; x.sb = 1'b1;
    step(OP_LOAD, 1'b0, rb(), rb(), 1'b0, x);
    x = blank(S_MEM);
    step(OP_LOAD, 1'b1, rb(), rb(), 1'b1, x);
  endtask

  logic [6:0] ops [9];

  initial begin
    ops[0] = OP_RTYPE;  ops[1] = OP_IARITH; ops[2] = OP_LOAD;
    ops[3] = OP_STORE;  ops[4] = OP_BRANCH; ops[5] = OP_JAL;
    ops[6] = OP_JALR;   ops[7] = OP_SYSTEM; ops[8] = 7'b1111111;

    reset = 1'b1; bus.opcode = '0; bus.mem_ready = 1'b0;
    bus.bcond = 1'b0; bus.halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(7'd0, 1'b1, 1'b0, 1'b0, 1'b1, blank(S_IF));

    run_instr(OP_RTYPE, 1, 0, 1'b0, 1'b0);
    run_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0);
    run_instr(OP_BRANCH, 0, 0, 1'b0, 1'b0);
    run_instr(OP_LOAD, 0, 2, 1'b0, 1'b0);
    run_instr(OP_STORE, 1, 1, 1'b0, 1'b0);
    run_instr(OP_RTYPE, TO + 1, 0, 1'b0, 1'b0);
    if (m_halt) recover();
    run_instr(OP_LOAD, 0, TO + 1, 1'b0, 1'b0);
    if (m_halt) recover();
    run_instr(OP_SYSTEM, 0, 0, 1'b0, 1'b1);
    if (m_halt) recover();
    run_instr(7'b1111111, 0, 0, 1'b0, 1'b0);
    reset_in_mem();
    run_instr(OP_IARITH, 0, 0, 1'b0, 1'b0);
    run_instr(OP_JAL, 2, 0, 1'b0, 1'b0);
    run_instr(OP_JALR, 0, 0, 1'b1, 1'b0);
    run_instr(OP_LOAD, 0, TO, 1'b0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      int   c, ifn, memn;
      c    = int'($urandom_range(0, 8));
      ifn  = ($urandom % 30 == 0) ? TO + 1 : int'($urandom_range(0, 3));
      memn = ($urandom % 20 == 0) ? TO + 1 : int'($urandom_range(0, TO));
      run_instr(ops[c], ifn, memn, rb(), rb());
      if (m_halt) recover();
    end

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the maximum number of cycles a memory access may wait for mem_ready.
REQ-002 Clock is `clk`, input, 1 bit; there is one clock and all state updates on its rising edge.
REQ-003 Reset is `reset`, input, 1 bit; it is synchronous and active-high.
REQ-004 `opcode`, input, 7 bits, is IR[6:0] from the datapath, stable from ID until the next IF completes.
REQ-005 `bcond`, input, 1 bit, is the branch condition from the ALU, valid in EX.
REQ-006 `mem_ready`, input, 1 bit, is the memory completion pulse for the current access.
REQ-007 `halt_req`, input, 1 bit, means the datapath has detected ECALL with x17==10.
REQ-008 `pc_write`, output, 1 bit, is the PC write enable.
REQ-009 `i_or_d`, output, 1 bit, selects the memory address: 0=PC, 1=ALUOut.
REQ-010 `mem_read` and `mem_write`, outputs, 1 bit each, are the memory strobes.
REQ-011 `ir_write`, output, 1 bit, is the IR and opcode capture enable.
REQ-012 `reg_write`, output, 1 bit, is the register file write enable.
REQ-013 `mem_to_reg`, output, 2 bits, selects write-back data: 0=ALUOut, 1=MDR, 2=PC+4.
REQ-014 `alu_src_a`, output, 1 bit, selects ALU operand A: 0=PC, 1=A.
REQ-015 `alu_src_b`, output, 1 bit, selects ALU operand B: 0=B, 1=imm.
REQ-016 `alu_op`, output, 2 bits, selects the ALU operation: 0=add, 1=branch compare, 2=funct decode.
REQ-017 `pc_source`, output, 1 bit, selects the next PC: 0=PC+4 from the dedicated adder, 1=ALUOut.
REQ-018 `is_halted`, output, 1 bit; `mem_error`, output, 1 bit; `state`, output, 3 bits (current state).

Function
REQ-019 States and encodings SHALL be: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; encodings 6 and 7 SHALL go to IF.
REQ-020 Outputs SHALL be combinational from state, opcode, mem_ready and bcond; any control not listed for a state SHALL be 0.
REQ-021 IF SHALL assert mem_read with i_or_d=0; on mem_ready it SHALL assert ir_write and go to ID, and otherwise stay in IF.
REQ-022 ID SHALL set alu_src_a=0, alu_src_b=1, alu_op=0 (ALUOut<=PC+imm).
- ECALL opcode: if halt is enabled and halt_req=1, go to HALT; otherwise assert pc_write with pc_source=0 and go to IF.
- Unknown opcode: pc_write with pc_source=0, go to IF.
- All other opcodes: go to EX.
REQ-023 EX for R-type SHALL set alu_src_a=1, alu_src_b=0, alu_op=2; for I-arith the same with alu_src_b=1; both go to WB.
REQ-024 EX for LOAD/STORE SHALL set alu_src_a=1, alu_src_b=1, alu_op=0 and go to MEM.
REQ-025 EX for BRANCH SHALL set alu_src_a=1, alu_src_b=0, alu_op=1 and assert pc_write with pc_source=bcond, then go to IF.
REQ-026 EX for JALR SHALL set alu_src_a=1, alu_src_b=1, alu_op=0; EX for JAL drives no controls; both go to WB.
REQ-027 MEM for LOAD SHALL assert mem_read with i_or_d=1 and go to WB on mem_ready.
REQ-028 MEM for STORE SHALL assert mem_write with i_or_d=1; on mem_ready it SHALL assert pc_write with pc_source=0 and go to IF.
REQ-029 WB SHALL assert reg_write and pc_write; mem_to_reg=0 for arithmetic, 1 for LOAD, 2 for JAL/JALR; pc_source=1 for JAL/JALR, otherwise 0; then go to IF.
REQ-030 The wait counter SHALL clear on entry to IF or MEM and increment each cycle of the wait without mem_ready.
REQ-031 If the wait counter equals MEM_TIMEOUT with mem_ready=0, the block SHALL go to HALT and set mem_error (sticky); mem_ready in that same cycle SHALL win over the timeout.
REQ-032 HALT SHALL be absorbing: is_halted=1 and every enable is 0 until reset.

Reset
REQ-033 While reset=1, all write and strobe enables SHALL be forced to 0; at the next edge state<=IF, the counter<=0, mem_error<=0, is_halted<=0.
REQ-034 Reset mid-access SHALL abandon the access, with no pc_write or reg_write in that cycle; reset SHALL override mem_ready.

Configuration
REQ-035 With ECALL_HALT_EN defined, ECALL with halt_req=1 in ID SHALL enter HALT; without it, ECALL SHALL behave as a no-op with PC+4, and is_halted SHALL be driven only by a timeout.

Structure
REQ-036 The shared opcodes package/header SHALL hold the opcode constants, state encodings, and the alu_op, mem_to_reg and pc_source codes.
REQ-037 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer.

Verification
REQ-038 ADD with mem_ready on the 2nd IF cycle: states IF,IF,ID,EX,WB; in WB reg_write=1, pc_write=1, pc_source=0.
REQ-039 BEQ with bcond=1, then BEQ with bcond=0: EX pc_source is 1, then 0; each returns to IF with no WB.
REQ-040 LW with a 3-cycle MEM wait: mem_read held 3 cycles, then WB with mem_to_reg=1; SW: pc_write is asserted in MEM on mem_ready.
REQ-041 MEM_TIMEOUT=4 with mem_ready held low in IF: state=HALT after 5 cycles, mem_error=1, held until reset.
REQ-042 ECALL with halt_req=1: HALT with ECALL_HALT_EN, PC+4 and IF without it; reset asserted in MEM: state=IF next cycle and no writes.
